// File: rtl/bcd_run_controller_pkg.sv
// Shared types for the BCD counter run/stop/clear sequencer.
package bcd_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // The limit that matters is the one we are counting towards.
  function automatic logic at_terminal(input logic dir,
                                       input logic at_max,
                                       input logic at_min);
    return dir ? at_min : at_max;
  endfunction

endpackage

// File: rtl/bcd_run_controller_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stability debounce, and a
// one-cycle pulse on each accepted press.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic clk_100Mhz,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/bcd_run_controller.sv
// Run/stop/clear sequencer for the 3-digit BCD counter: conditions the
// buttons, paces count steps and stops at the terminal value in one-shot mode.
module bcd_run_controller
  import bcd_run_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 20000000,
  parameter int unsigned TICK_W     = 25,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       sw_dir,
  input  logic       sw_oneshot,
  input  logic       cnt_at_max,
  input  logic       cnt_at_min,
  output logic       step,
  output logic       dir,
  output logic       clr,
  output logic [1:0] state,
  output logic       done
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic start_p, stop_p, clear_p;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_start (
    .clk_100Mhz(clk_100Mhz), .reset(reset), .raw(btn_start), .press(start_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_stop (
    .clk_100Mhz(clk_100Mhz), .reset(reset), .raw(btn_stop), .press(stop_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clear (
    .clk_100Mhz(clk_100Mhz), .reset(reset), .raw(btn_clear), .press(clear_p)
  );

  logic              dir_s1_q, dir_s2_q, os_s1_q, os_s2_q;
  logic              dir_q, dir_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  state_e            state_q, state_d;
  logic              step_q, step_d;
  logic              clr_q, clr_d;
  logic              done_q, done_d;
  logic              is_tick;

  assign is_tick = (tick_q == TICK_LAST);
  assign dir_d   = dir_s2_q;

  // Priority clear > stop > start > tick; the tick counter only moves in RUN.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_p) begin
          clr_d = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
          tick_d  = '0;
        end
      end
      ST_RUN: begin
        if (clear_p) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (stop_p) begin
          state_d = ST_PAUSE;
        end else if (is_tick) begin
          tick_d = '0;
          if (os_s2_q && at_terminal(dir_q, cnt_at_max, cnt_at_min)) begin
            state_d = ST_DONE;
          end else begin
            step_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clear_p) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear_p) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      dir_s1_q <= 1'b0;
      dir_s2_q <= 1'b0;
      os_s1_q  <= 1'b0;
      os_s2_q  <= 1'b0;
      dir_q    <= 1'b0;
      tick_q   <= '0;
      state_q  <= ST_IDLE;
      step_q   <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      dir_s1_q <= sw_dir;
      dir_s2_q <= dir_s1_q;
      os_s1_q  <= sw_oneshot;
      os_s2_q  <= os_s1_q;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      step_q   <= step_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign clr   = clr_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_run_controller.sv
// Scoreboard bench for bcd_run_controller with TICK_DIV=8, DEB_CYCLES=4.
module tb_bcd_run_controller;

  logic       clk_100Mhz;
  logic       reset;
  logic       btn_start, btn_stop, btn_clear;
  logic       sw_dir, sw_oneshot;
  logic       cnt_at_max, cnt_at_min;
  logic       step, dir, clr, done;
  logic [1:0] state;

  bcd_run_controller #(
    .TICK_DIV(8), .TICK_W(4), .DEB_CYCLES(4), .DEB_W(3)
  ) dut (
    .clk_100Mhz(clk_100Mhz), .reset(reset),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .sw_dir(sw_dir), .sw_oneshot(sw_oneshot),
    .cnt_at_max(cnt_at_max), .cnt_at_min(cnt_at_min),
    .step(step), .dir(dir), .clr(clr), .state(state), .done(done)
  );

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  int cyc = 0;
  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  // Expected output event: cycle it appears and {step,clr,state,done,dir}.
  typedef struct {
    int       c;
    logic [5:0] o;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic push(input int c, input logic s, input logic cl,
                      input logic [1:0] st, input logic d, input logic dr);
    ev_t e;
    e.c = c;
    e.o = {s, cl, st, d, dr};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100Mhz);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Monitor: any step/clr pulse or state/done change is an event to score.
  logic [1:0] prev_state = IDLE;
  logic       prev_done  = 1'b0;
  always @(negedge clk_100Mhz) begin
    if (mon_en) begin
      if (step || clr || state != prev_state || done != prev_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got {step,clr,state,done,dir}=%b at cycle %0d, none expected",
                   {step, clr, state, done, dir}, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.c);
          chk("event_outputs", {26'd0, step, clr, state, done, dir}, {26'd0, e.o});
        end
      end
      prev_state = state;
      prev_done  = done;
    end
  end

  initial begin
    int e, p, c, s, m;
    reset = 1'b1;
    btn_start = 0; btn_stop = 0; btn_clear = 0;
    sw_dir = 0; sw_oneshot = 0; cnt_at_max = 0; cnt_at_min = 0;
    tick(3);
    chk("reset_state", state, IDLE);
    chk("reset_step", step, 0);
    chk("reset_clr", clr, 0);
    chk("reset_done", done, 0);
    chk("reset_dir", dir, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle, then a 2-cycle glitch on start: nothing may happen.
    tick(50);
    chk("idle_state", state, IDLE);
    btn_start = 1; tick(2); btn_start = 0;
    tick(20);
    chk("glitch_state", state, IDLE);

    // Start held 10 cycles: RUN at +7, steps every 8, stop lands on the 3rd tick.
    e = cyc;
    btn_start = 1;
    push(e + 7,  0, 0, RUN,   0, 0);
    push(e + 15, 1, 0, RUN,   0, 0);
    push(e + 23, 1, 0, RUN,   0, 0);
    push(e + 31, 0, 0, PAUSE, 0, 0);
    wait_until(e + 10); btn_start = 0;
    wait_until(e + 24); btn_stop = 1;
    wait_until(e + 30); btn_stop = 0;

    // Resume: phase was held at the tick, so the step comes one cycle later.
    wait_until(e + 40);
    p = cyc;
    btn_start = 1;
    push(p + 7, 0, 0, RUN, 0, 0);
    push(p + 8, 1, 0, RUN, 0, 0);
    wait_until(p + 6); btn_start = 0;

    // One-shot at max: next tick goes DONE with no step.
    wait_until(p + 9);
    sw_oneshot = 1; cnt_at_max = 1;
    push(p + 16, 0, 0, DONE, 1, 0);
    wait_until(p + 20); btn_start = 1; btn_stop = 1;
    wait_until(p + 26); btn_start = 0; btn_stop = 0;
    wait_until(p + 40);
    c = cyc;
    btn_clear = 1;
    push(c + 7, 0, 1, IDLE, 0, 0);
    wait_until(c + 6); btn_clear = 0;

    // Wrap mode counting down with min flag set: steps continue, dir=1.
    wait_until(c + 20);
    sw_oneshot = 0; cnt_at_max = 0; cnt_at_min = 1; sw_dir = 1;
    tick(10);
    s = cyc;
    btn_start = 1;
    push(s + 7,  0, 0, RUN, 0, 1);
    push(s + 15, 1, 0, RUN, 0, 1);
    push(s + 23, 1, 0, RUN, 0, 1);
    push(s + 31, 1, 0, RUN, 0, 1);
    push(s + 39, 1, 0, RUN, 0, 1);
    push(s + 40, 0, 1, IDLE, 0, 1);
    wait_until(s + 6); btn_start = 0;
    // Clear and stop in the same cycle: clear wins.
    wait_until(s + 33); btn_clear = 1; btn_stop = 1;
    wait_until(s + 39); btn_clear = 0; btn_stop = 0;

    // Reset mid-RUN: everything to 0 on the next edge, no clr pulse.
    wait_until(s + 55);
    m = cyc;
    btn_start = 1;
    push(m + 7,  0, 0, RUN,  0, 1);
    push(m + 15, 1, 0, RUN,  0, 1);
    push(m + 19, 0, 0, IDLE, 0, 0);
    wait_until(m + 6); btn_start = 0;
    wait_until(m + 18);
    reset = 1'b1;
    tick(1);
    chk("midreset_state", state, IDLE);
    chk("midreset_step", step, 0);
    chk("midreset_clr", clr, 0);
    chk("midreset_done", done, 0);
    tick(1);
    reset = 1'b0;
    tick(30);

    chk("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
